// File: rtl/aes_256_inv_iter.sv
// Iterative AES-256 inverse cipher: one round per clock,
// round keys regenerated on the fly from a sliding 8-word window.
`timescale 1ns/1ps
module aes_256_inv_iter #(
  parameter bit ZEROIZE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] state,
  input  logic [255:0] key,
  output logic [127:0] out,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    ROUND,
    FINISH
  } fsm_t;

  fsm_t         fsm_q;
  logic [3:0]   cnt_q;
  logic [127:0] s_q;
  logic [127:0] rka_q;
  logic [127:0] rkb_q;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse (and maps 0 to 0)
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x240;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x240 = gmul(x15, x15);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    return gmul(gmul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] i;
    i = ginv(x);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]}
             ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] a;
    a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]}
      ^ {x[1:0], x[7:2]} ^ 8'h05;
    return ginv(a);
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]),  sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] inv_shift(input logic [127:0] a);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = a[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub(input logic [127:0] a);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv_sbox(a[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] a);
    return {inv_mix_col(a[127:96]), inv_mix_col(a[95:64]),
            inv_mix_col(a[63:32]),  inv_mix_col(a[31:0])};
  endfunction

  logic         fwd;
  logic         use_rot;
  logic [3:0]   ridx;
  logic [7:0]   rcon;
  logic [31:0]  kw;
  logic [31:0]  kt;
  logic [127:0] kn_fwd;
  logic [127:0] kn_bwd;
  logic [127:0] x_in;
  logic [127:0] y_rk;
  logic [127:0] rnd;

  // One shared SubWord serves both directions of the key walk
  always_comb begin
    fwd     = (fsm_q == EXPAND);
    kw      = fwd ? rkb_q[31:0] : rka_q[31:0];
    use_rot = fwd ? ~cnt_q[0] : cnt_q[0];
    ridx    = fwd ? (cnt_q >> 1) + 4'd1
                  : (cnt_q + 4'd1) >> 1;
    rcon    = 8'h01 << (ridx - 4'd1);
    kt      = use_rot ? subword({kw[23:0], kw[31:24]}) ^ {rcon, 24'h0}
                      : subword(kw);
    kn_fwd[127:96] = rka_q[127:96] ^ kt;
    kn_fwd[95:64]  = rka_q[95:64]  ^ kn_fwd[127:96];
    kn_fwd[63:32]  = rka_q[63:32]  ^ kn_fwd[95:64];
    kn_fwd[31:0]   = rka_q[31:0]   ^ kn_fwd[63:32];
    kn_bwd[127:96] = rkb_q[127:96] ^ kt;
    kn_bwd[95:64]  = rkb_q[95:64]  ^ rkb_q[127:96];
    kn_bwd[63:32]  = rkb_q[63:32]  ^ rkb_q[95:64];
    kn_bwd[31:0]   = rkb_q[31:0]   ^ rkb_q[63:32];
  end

  always_comb begin
    x_in = (cnt_q == 4'd13) ? s_q ^ rkb_q : s_q;
    y_rk = inv_sub(inv_shift(x_in)) ^ rka_q;
    rnd  = (cnt_q == 4'd0) ? y_rk : inv_mix(y_rk);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= IDLE;
      cnt_q <= '0;
      s_q   <= '0;
      rka_q <= '0;
      rkb_q <= '0;
      out   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (fsm_q)
        IDLE: begin
          if (start) begin
            s_q   <= state;
            rka_q <= key[255:128];
            rkb_q <= key[127:0];
            cnt_q <= '0;
            busy  <= 1'b1;
            fsm_q <= EXPAND;
          end else if (ZEROIZE) begin
            s_q   <= '0;
            rka_q <= '0;
            rkb_q <= '0;
            cnt_q <= '0;
          end
        end
        EXPAND: begin
          rka_q <= rkb_q;
          rkb_q <= kn_fwd;
          if (cnt_q == 4'd12) begin
            cnt_q <= 4'd13;
            fsm_q <= ROUND;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ROUND: begin
          s_q   <= rnd;
          rka_q <= kn_bwd;
          rkb_q <= rka_q;
          if (cnt_q == 4'd0) fsm_q <= FINISH;
          else cnt_q <= cnt_q - 4'd1;
        end
        FINISH: begin
          out   <= s_q;
          done  <= 1'b1;
          busy  <= 1'b0;
          fsm_q <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_256_inv_iter.sv
// Scoreboard bench for aes_256_inv_iter: known vectors, handshake
// corner cases and an encrypt/decrypt loop-back with a local model.
`timescale 1ns/1ps
module tb_aes_256_inv_iter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] state = '0;
  logic [255:0] key = '0;
  logic [127:0] out;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  aes_256_inv_iter #(.ZEROIZE(1'b1)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .state (state),
    .key   (key),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  localparam logic [255:0] K1 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C1 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K2 =
    256'h2b7e151628aed2a6abf7158809cf4f3c762e7160f38b4da56a784d9045190cfe;
  localparam logic [127:0] C2 = 128'h1a6e6c2c662e7da6501ffb62bc9e93f3;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C3 = 128'hdc95c078a2408989ad48a21492842087;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] pt;
    int           t0;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (!rst && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done out=%h", out);
      end else begin
        mon_e = exp_q.pop_front();
        if (out !== mon_e.pt) begin
          errors++;
          $display("FAIL plaintext got=%h exp=%h", out, mon_e.pt);
        end
        checks++;
        if (cyc - mon_e.t0 != 28) begin
          errors++;
          $display("FAIL latency got=%0d exp=28", cyc - mon_e.t0);
        end
      end
    end
  end

  // Reference encryptor; S-box built from exp/log tables
  logic [7:0] sb [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  task automatic build_sbox();
    logic [7:0] ex [256];
    int         lg [256];
    logic [7:0] iv;
    ex[0] = 8'h01;
    for (int i = 0; i < 255; i++) begin
      lg[ex[i]] = i;
      ex[i+1] = ex[i] ^ xt(ex[i]);
    end
    sb[0] = 8'h63;
    for (int x = 1; x < 256; x++) begin
      iv = ex[(255 - lg[x]) % 255];
      sb[x] = iv ^ {iv[6:0], iv[7]} ^ {iv[5:0], iv[7:6]}
            ^ {iv[4:0], iv[7:5]} ^ {iv[3:0], iv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [127:0] aes_enc(input logic [255:0] k,
                                           input logic [127:0] p);
    logic [31:0]  w [60];
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int i = 0; i < 16; i++)
      st[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 14; r++) begin
      for (int i = 0; i < 16; i++) tmp[i] = sb[st[i]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          st[rr+4*c] = tmp[rr+4*((c+rr)%4)];
      if (r < 14) begin
        for (int c = 0; c < 4; c++) begin
          a0 = st[4*c];   a1 = st[4*c+1];
          a2 = st[4*c+2]; a3 = st[4*c+3];
          st[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          st[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          st[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          st[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++)
        st[i] = st[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = st[i];
    return o;
  endfunction

  task automatic send(input logic [255:0] k, input logic [127:0] c,
                      input logic [127:0] p, input bit push);
    @(negedge clk);
    start = 1'b1;
    key   = k;
    state = c;
    if (push) exp_q.push_back('{pt: p, t0: cyc + 1});
    @(negedge clk);
    start = 1'b0;
    key   = {$urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom};
    state = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout pending=%0d exp=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #12;
    checks += 3;
    if (out !== '0) begin
      errors++; $display("FAIL reset_out got=%h exp=0", out);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got=%b exp=0", busy);
    end
    if (done !== 1'b0) begin
      errors++; $display("FAIL reset_done got=%b exp=0", done);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    send(K1, C1, P1, 1'b1);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL busy_after_accept got=%b exp=1", busy);
    end
    wait_idle(40, "vec1");
    send(K2, C2, P2, 1'b1);
    wait_idle(40, "vec2");
  endtask

  task automatic test_back_to_back();
    int n = 0;
    send('0, C3, '0, 1'b1);
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL b2b_done got=%b exp=1", done);
    end else begin
      checks++;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL b2b_busy got=%b exp=0", busy);
      end
      start = 1'b1;
      key   = K1;
      state = C1;
      exp_q.push_back('{pt: P1, t0: cyc + 1});
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle(40, "b2b");
  endtask

  task automatic test_busy_ignore();
    send(K1, C1, P1, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1;
    key   = K2;
    state = C2;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL ignore_busy got=%b exp=1", busy);
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle(40, "ignore");
    repeat (35) @(negedge clk);
    checks++;
    if (out !== P1) begin
      errors++; $display("FAIL ignore_out got=%h exp=%h", out, P1);
    end
  endtask

  task automatic test_reset_abort();
    send(K1, C1, P1, 1'b1);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q.delete();
    checks += 3;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL abort_busy got=%b exp=0", busy);
    end
    if (done !== 1'b0) begin
      errors++; $display("FAIL abort_done got=%b exp=0", done);
    end
    if (out !== '0) begin
      errors++; $display("FAIL abort_out got=%h exp=0", out);
    end
    @(negedge clk);
    rst = 1'b0;
    send(K2, C2, P2, 1'b1);
    wait_idle(40, "after_abort");
  endtask

  task automatic test_loopback();
    logic [255:0] k;
    logic [127:0] p;
    logic [127:0] c;
    for (int i = 0; i < 16; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      c = aes_enc(k, p);
      send(k, c, p, 1'b1);
      wait_idle(40, "loop");
      @(negedge clk);
      #1;
      checks++;
      if (dut.s_q !== '0 || dut.rka_q !== '0 || dut.rkb_q !== '0) begin
        errors++;
        $display("FAIL zeroize s=%h rka=%h rkb=%h exp=0",
                 dut.s_q, dut.rka_q, dut.rkb_q);
      end
      checks++;
      if (out !== p) begin
        errors++; $display("FAIL loop_hold got=%h exp=%h", out, p);
      end
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_vectors();
    test_back_to_back();
    test_busy_ignore();
    test_reset_abort();
    test_loopback();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
